game_input_ctrl: RTL and testbench
==================================

GAME_INPUT_CTRL -- requirements
Module: game_input_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 500000, meaning stable-level cycles required to accept a press or release.
REQ-002 SHALL have parameter SKIP_CYCLES, default 100000000, meaning idle PLAY cycles before an auto-skip Pulse.
REQ-003 SHALL have parameter LFSR_SEED, 16 bits, default 16'hACE1, meaning LFSR reset value.
REQ-004 SHALL have port Clk, input, 1 bit, system clock; all logic is rising-edge.
REQ-005 SHALL have port Reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have ports BtnL_raw, BtnR_raw and BtnC_raw, inputs, 1 bit each, asynchronous raw push-buttons (left, right, center).
REQ-007 SHALL have port Enable, input, 1 bit, high while the game consumer is in its PLAY state.
REQ-008 SHALL have ports LEFT_Btn and RIGHT_Btn, outputs, 1 bit each, single-cycle debounced press pulses.
REQ-009 SHALL have port StartAck, output, 1 bit, single-cycle debounced center press pulse.
REQ-010 SHALL have port Pulse, output, 1 bit, single-cycle skip-timeout pulse.
REQ-011 SHALL have port rand, output, 1 bit, registered pseudo-random bit.

Function
REQ-012 SHALL pass each raw button through a 2-flop synchronizer before any other logic.
REQ-013 SHALL give each button an independent FSM with states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE, plus a counter of width ceil(log2(DB_CYCLES+1)).
REQ-014 IDLE: SHALL go to WAIT_PRESS with count 0 when the synced level is 1.
REQ-015 WAIT_PRESS: SHALL increment count while level is 1, return to IDLE on level 0, and go to PRESSED when count reaches DB_CYCLES-1 with level 1.
REQ-016 PRESSED: SHALL last exactly one cycle, assert that button's pulse for that cycle, then go to WAIT_RELEASE with count 0.
REQ-017 WAIT_RELEASE: SHALL increment count while level is 0, clear count on level 1, and go to IDLE when count reaches DB_CYCLES-1 with level 0.
REQ-018 SHALL emit at most one pulse per physical press, and none while a button is held.
REQ-019 SHALL produce a pulse exactly DB_CYCLES+2 cycles after a clean rising edge of the raw input (2 sync cycles plus DB_CYCLES count cycles).
REQ-020 SHALL assert only LEFT_Btn when the left and right pulses coincide, dropping the right pulse.
REQ-021 SHALL leave StartAck ungated by Enable and independent of LEFT_Btn and RIGHT_Btn.
REQ-022 SHALL gate LEFT_Btn and RIGHT_Btn with Enable, so that presses completing while Enable=0 are discarded.
REQ-023 Skip timer: SHALL hold the counter at 0 while Enable=0, and SHALL clear it in any cycle where LEFT_Btn or RIGHT_Btn is asserted.
REQ-024 Skip timer: otherwise SHALL increment the counter, and on reaching SKIP_CYCLES-1 SHALL assert Pulse for one cycle and reload 0.
REQ-025 SHALL suppress Pulse and clear the counter when a button pulse and the timer terminal count occur in the same cycle.
REQ-026 SHALL never assert Pulse together with LEFT_Btn or RIGHT_Btn.
REQ-027 LFSR: SHALL be 16-bit Fibonacci with polynomial x^16+x^14+x^13+x^11+1, shifting every cycle regardless of Enable.
REQ-028 rand: SHALL be registered from LFSR bit 0 each cycle.
REQ-029 SHALL load 16'h0001 instead when LFSR_SEED is 0, so that all-zero lockup is impossible.
REQ-030 SHALL update all outputs from registers only, with no combinational path from inputs to outputs.

Reset
REQ-031 On Reset=1, SHALL set all pulse outputs (LEFT_Btn, RIGHT_Btn, StartAck, Pulse) to 0, debounce FSMs to IDLE, all counters to 0, synchronizers to 0, LFSR to LFSR_SEED (or 1), and rand to 0, immediately and asynchronously.
REQ-032 SHALL abandon any in-progress debounce or timeout on a Reset asserted mid-operation, with no pulse emitted after release until a full new qualification.

Verification
REQ-033 Using DB_CYCLES=4 and SKIP_CYCLES=16: Enable=1, BtnL_raw held high for 20 cycles -> exactly one LEFT_Btn pulse, 6 cycles after the edge, and no Pulse.
REQ-034 BtnR_raw toggling every 2 cycles (bounce) for 12 cycles, then stable high -> no RIGHT_Btn during bounce, one pulse 6 cycles after the final rising edge.
REQ-035 Enable=1 with no presses for 40 cycles -> Pulse at cycles 16 and 32 after Enable rises, each 1 cycle wide.
REQ-036 Left pulse landing on the timer terminal cycle -> LEFT_Btn=1, Pulse=0, next Pulse 16 cycles later.
REQ-037 Enable=0 while BtnL_raw and BtnC_raw are pressed -> StartAck pulses once, LEFT_Btn stays 0, Pulse stays 0.
REQ-038 Reset asserted mid-WAIT_PRESS -> outputs 0 at once, and LFSR sequence restarts at 16'hACE1 (rand sequence repeatable across two resets).

Source files
------------

// File: rtl/game_input_ctrl.sv
// Game input front end: three debounced push-buttons, a PLAY-state skip timer
// and a free-running LFSR random bit. The random output is rand_bit (rand is a reserved word).
module game_input_ctrl #(
    parameter int          DB_CYCLES   = 500000,
    parameter int          SKIP_CYCLES = 100000000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic BtnL_raw,
    input  logic BtnR_raw,
    input  logic BtnC_raw,
    input  logic Enable,
    output logic LEFT_Btn,
    output logic RIGHT_Btn,
    output logic StartAck,
    output logic Pulse,
    output logic rand_bit
);

    localparam int CNT_W  = $clog2(DB_CYCLES + 1);
    localparam int SKIP_W = $clog2(SKIP_CYCLES + 1);

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_CYCLES - 1);
    localparam logic [15:0]       SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_PRESS   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;

    // Bit order for all per-button vectors: [0]=left, [1]=right, [2]=center.
    logic [2:0] sync_1;
    logic [2:0] level;
    logic [2:0] press;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_1 <= '0;
            level  <= '0;
        end else begin
            sync_1 <= {BtnC_raw, BtnR_raw, BtnL_raw};
            level  <= sync_1;
        end
    end

    for (genvar b = 0; b < 3; b++) begin : g_btn
        logic [1:0]       state;
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] count_inc;
        logic             qualified;

        // Qualify on the cycle the count reaches DB_LAST, so the IDLE cycle counts as the first stable one.
        assign count_inc = count + 1'b1;
        assign qualified = (count_inc >= DB_LAST);

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (level[b]) begin
                            state <= WAIT_PRESS;
                            count <= '0;
                        end
                    end
                    WAIT_PRESS: begin
                        if (!level[b])
                            state <= IDLE;
                        else if (qualified)
                            state <= PRESSED;
                        else
                            count <= count_inc;
                    end
                    PRESSED: begin
                        state <= WAIT_RELEASE;
                        count <= '0;
                    end
                    WAIT_RELEASE: begin
                        if (level[b])
                            count <= '0;
                        else if (qualified)
                            state <= IDLE;
                        else
                            count <= count_inc;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        // High on the edge that enters PRESSED; the registered pulse spans exactly the PRESSED cycle.
        assign press[b] = (state == WAIT_PRESS) && level[b] && qualified;
    end

    logic left_next;
    logic right_next;

    assign left_next  = press[0] & Enable;
    assign right_next = press[1] & Enable & ~left_next;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            LEFT_Btn  <= 1'b0;
            RIGHT_Btn <= 1'b0;
            StartAck  <= 1'b0;
        end else begin
            LEFT_Btn  <= left_next;
            RIGHT_Btn <= right_next;
            StartAck  <= press[2];
        end
    end

    logic [SKIP_W-1:0] skip_count;

    // A button pulse wins over the terminal count, so Pulse never coincides with a button.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            skip_count <= '0;
            Pulse      <= 1'b0;
        end else if (!Enable || left_next || right_next) begin
            skip_count <= '0;
            Pulse      <= 1'b0;
        end else if (skip_count == SKIP_LAST) begin
            skip_count <= '0;
            Pulse      <= 1'b1;
        end else begin
            skip_count <= skip_count + 1'b1;
            Pulse      <= 1'b0;
        end
    end

    logic [15:0] lfsr;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr     <= SEED_EFF;
            rand_bit <= 1'b0;
        end else begin
            lfsr     <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            rand_bit <= lfsr[0];
        end
    end

endmodule

// File: tb/tb_game_input_ctrl.sv
// Self-checking bench for game_input_ctrl: directed scenarios plus random button
// traffic, all compared every cycle against a run-length behavioural model.
module tb_game_input_ctrl;

    localparam int          DB   = 4;
    localparam int          SKIP = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic Clk = 1'b0;
    logic Reset;
    logic BtnL_raw, BtnR_raw, BtnC_raw, Enable;
    logic LEFT_Btn, RIGHT_Btn, StartAck, Pulse, rand_bit;

    game_input_ctrl #(
        .DB_CYCLES  (DB),
        .SKIP_CYCLES(SKIP),
        .LFSR_SEED  (SEED)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .BtnL_raw (BtnL_raw),
        .BtnR_raw (BtnR_raw),
        .BtnC_raw (BtnC_raw),
        .Enable   (Enable),
        .LEFT_Btn (LEFT_Btn),
        .RIGHT_Btn(RIGHT_Btn),
        .StartAck (StartAck),
        .Pulse    (Pulse),
        .rand_bit (rand_bit)
    );

    always #5 Clk = ~Clk;

    int n_check = 0;
    int n_pass  = 0;

    // Model: raw samples delayed two cycles, then run lengths of stable level per button.
    logic [2:0]  m_s1, m_s2;
    int          m_run [3];
    bit          m_held[3];
    bit          m_gap [3];
    int          m_idle;
    logic [15:0] m_lfsr;
    logic        exp_l, exp_r, exp_c, exp_p, exp_rand;

    int          cyc;
    int          n_left, n_right, n_start, n_pulse;
    int          left_at, right_at, pulse_first, pulse_last;
    logic [15:0] rand_word;
    logic [15:0] exp_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h1;
        return (s >> 1) | (16'(fb) << 15);
    endfunction

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        for (int b = 0; b < 3; b++) begin
            m_run[b]  = 0;
            m_held[b] = 1'b0;
            m_gap[b]  = 1'b0;
        end
        m_idle   = 0;
        m_lfsr   = SEED;
        exp_l    = 1'b0;
        exp_r    = 1'b0;
        exp_c    = 1'b0;
        exp_p    = 1'b0;
        exp_rand = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] press;
        logic       lv;
        if (Reset) begin
            model_reset();
            return;
        end
        press = '0;
        for (int b = 0; b < 3; b++) begin
            lv = m_s2[b];
            if (!m_held[b]) begin
                m_run[b] = lv ? m_run[b] + 1 : 0;
                if (m_run[b] == DB) begin
                    press[b]  = 1'b1;
                    m_held[b] = 1'b1;
                    m_gap[b]  = 1'b1;
                    m_run[b]  = 0;
                end
            end else if (m_gap[b]) begin
                m_gap[b] = 1'b0;
            end else begin
                m_run[b] = lv ? 0 : m_run[b] + 1;
                if (m_run[b] == DB - 1) begin
                    m_held[b] = 1'b0;
                    m_run[b]  = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = {BtnC_raw, BtnR_raw, BtnL_raw};

        exp_l = press[0] & Enable;
        exp_r = press[1] & Enable & ~exp_l;
        exp_c = press[2];

        exp_p = 1'b0;
        if (!Enable || exp_l || exp_r) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == SKIP) begin
                exp_p  = 1'b1;
                m_idle = 0;
            end
        end

        exp_rand = m_lfsr[0];
        m_lfsr   = lfsr_step(m_lfsr);
    endtask

    task automatic clear_stats();
        cyc = 0;
        n_left = 0; n_right = 0; n_start = 0; n_pulse = 0;
        left_at = -1; right_at = -1; pulse_first = -1; pulse_last = -1;
        rand_word = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        cyc++;
        check("left",  LEFT_Btn,  exp_l);
        check("right", RIGHT_Btn, exp_r);
        check("start", StartAck,  exp_c);
        check("pulse", Pulse,     exp_p);
        check("rand",  rand_bit,  exp_rand);
        if (LEFT_Btn)  begin n_left++;  left_at  = cyc; end
        if (RIGHT_Btn) begin n_right++; right_at = cyc; end
        if (StartAck)  n_start++;
        if (Pulse) begin
            n_pulse++;
            if (pulse_first < 0) pulse_first = cyc;
            pulse_last = cyc;
        end
        if (cyc <= 16) rand_word[cyc-1] = rand_bit;
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        check({tag, "_left"},  LEFT_Btn,  1'b0);
        check({tag, "_right"}, RIGHT_Btn, 1'b0);
        check({tag, "_start"}, StartAck,  1'b0);
        check({tag, "_pulse"}, Pulse,     1'b0);
        check({tag, "_rand"},  rand_bit,  1'b0);
    endtask

    task automatic idle_release(input int n);
        BtnL_raw = 1'b0; BtnR_raw = 1'b0; BtnC_raw = 1'b0; Enable = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int          hold[3];
        logic [15:0] s;

        s = SEED;
        for (int k = 0; k < 16; k++) begin
            exp_word[k] = s[0];
            s = lfsr_step(s);
        end

        Reset = 1'b1;
        BtnL_raw = 1'b0; BtnR_raw = 1'b0; BtnC_raw = 1'b0; Enable = 1'b0;
        model_reset();
        clear_stats();
        check_reset_outputs("por");
        repeat (2) tick();
        Reset = 1'b0;

        // Held left press: one pulse DB+2 cycles after the edge, no skip pulse.
        Enable = 1'b1; BtnL_raw = 1'b1;
        clear_stats();
        repeat (20) tick();
        check("held_left_count", n_left, 1);
        check("held_left_at", left_at, DB + 2);
        check("held_no_pulse", n_pulse, 0);
        idle_release(8);

        // Bouncing right button, then stable high.
        Enable = 1'b1;
        clear_stats();
        for (int i = 0; i < 12; i++) begin
            BtnR_raw = ((i % 4) < 2);
            tick();
        end
        BtnR_raw = 1'b1;
        repeat (10) tick();
        check("bounce_right_count", n_right, 1);
        check("bounce_right_at", right_at, 13 + DB + 1);
        idle_release(8);

        // Idle PLAY: auto-skip every SKIP cycles.
        Enable = 1'b1;
        clear_stats();
        repeat (40) tick();
        check("skip_count", n_pulse, 2);
        check("skip_first", pulse_first, SKIP);
        check("skip_second", pulse_last, 2 * SKIP);
        idle_release(2);

        // Left pulse on the timer terminal cycle.
        Enable = 1'b1;
        clear_stats();
        repeat (SKIP - DB - 2) tick();
        BtnL_raw = 1'b1;
        repeat (DB + 2) tick();
        check("term_left", LEFT_Btn, 1'b1);
        check("term_pulse", Pulse, 1'b0);
        repeat (SKIP + 2) tick();
        check("term_next_count", n_pulse, 1);
        check("term_next_at", pulse_last, 2 * SKIP);
        idle_release(8);

        // Enable low: StartAck only.
        BtnL_raw = 1'b1; BtnC_raw = 1'b1;
        clear_stats();
        repeat (12) tick();
        check("dis_start", n_start, 1);
        check("dis_left", n_left, 0);
        check("dis_pulse", n_pulse, 0);
        idle_release(8);

        // Left and right completing together: left wins.
        Enable = 1'b1; BtnL_raw = 1'b1; BtnR_raw = 1'b1;
        clear_stats();
        repeat (10) tick();
        check("both_left", n_left, 1);
        check("both_right", n_right, 0);
        idle_release(8);

        // Reset mid-WAIT_PRESS, twice: full requalification and repeatable rand.
        for (int r = 0; r < 2; r++) begin
            Enable = 1'b1; BtnL_raw = 1'b1;
            clear_stats();
            repeat (4) tick();
            Reset = 1'b1;
            check_reset_outputs("mid_rst");
            repeat (2) tick();
            Reset = 1'b0;
            clear_stats();
            repeat (16) tick();
            check("rst_rand_word", rand_word, exp_word);
            check("rst_left_count", n_left, 1);
            check("rst_left_at", left_at, DB + 2);
            idle_release(8);
        end

        // Random button traffic with occasional Enable changes.
        Enable = 1'b1;
        for (int b = 0; b < 3; b++) hold[b] = 0;
        clear_stats();
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    hold[b] = $urandom_range(1, 9);
                    case (b)
                        0: BtnL_raw = 1'($urandom_range(0, 1));
                        1: BtnR_raw = 1'($urandom_range(0, 1));
                        default: BtnC_raw = 1'($urandom_range(0, 1));
                    endcase
                end else begin
                    hold[b]--;
                end
            end
            if ($urandom_range(0, 39) == 0) Enable = ~Enable;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
